// File: rtl/flappy_pkg.sv
// Shared colours, seven-segment geometry and the BCD converter state type
// for the Flappy Bird pixel path.
package flappy_pkg;

    localparam logic [7:0] BLACK = 8'h00;
    localparam logic [7:0] WHITE = 8'hFF;
    localparam logic [7:0] RED   = 8'hE0;
    localparam logic [7:0] GREEN = 8'h1C;
    localparam logic [7:0] BLUE  = 8'h03;

    // Digit cell is DIG_W wide, spanning SEG_TOP..SEG_BOT vertically.
    localparam logic [10:0] DIG_W   = 11'd80;
    localparam logic [10:0] STROKE  = 11'd10;
    localparam logic [10:0] SEG_TOP = 11'd160;
    localparam logic [10:0] SEG_MID = 11'd240;
    localparam logic [10:0] SEG_BOT = 11'd320;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

    // Segment order in every mask is {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_mask(input logic [3:0] d);
        case (d)
            4'd0:    seg_mask = 7'b1111110;
            4'd1:    seg_mask = 7'b0110000;
            4'd2:    seg_mask = 7'b1101101;
            4'd3:    seg_mask = 7'b1111001;
            4'd4:    seg_mask = 7'b0110011;
            4'd5:    seg_mask = 7'b1011011;
            4'd6:    seg_mask = 7'b1011111;
            4'd7:    seg_mask = 7'b1110000;
            4'd8:    seg_mask = 7'b1111111;
            4'd9:    seg_mask = 7'b1111011;
            default: seg_mask = 7'b0000000;
        endcase
    endfunction

    // dx is the column relative to the digit's left edge; a negative offset
    // wraps to a large value and so falls outside the cell.
    function automatic logic [6:0] seg_region(input logic [10:0] dx, input logic [10:0] y);
        logic full, left, right, upper, lower;
        full  = dx < DIG_W;
        left  = dx < STROKE;
        right = full && (dx >= DIG_W - STROKE);
        upper = (y >= SEG_TOP) && (y <= SEG_MID);
        lower = (y >= SEG_MID) && (y <= SEG_BOT);
        seg_region = {full && (y >= SEG_TOP) && (y < SEG_TOP + STROKE),
                      right && upper,
                      right && lower,
                      full && (y > SEG_BOT - STROKE) && (y <= SEG_BOT),
                      left && lower,
                      left && upper,
                      full && (y >= SEG_MID - (STROKE >> 1)) && (y < SEG_MID + (STROKE >> 1))};
    endfunction

endpackage

// File: rtl/flappy_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter feeding the score display;
// one bit per cycle so no dividers are needed.
module flappy_bin2bcd
    import flappy_pkg::*;
#(
    parameter int SCORE_W      = 8,
    parameter int SCORE_DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SCORE_W-1:0]        score,
    output logic [4*SCORE_DIGITS-1:0] digits,
    output logic                      busy
);

    localparam int          BCD_W   = 4 * SCORE_DIGITS;
    localparam int          CNT_W   = $clog2(SCORE_W + 1);
    localparam logic [31:0] MAX_VAL = 32'(10 ** SCORE_DIGITS - 1);

    bcd_state_t         state_reg;
    logic [SCORE_W-1:0] held_bin_reg;
    logic [SCORE_W-1:0] sh_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   digits_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SCORE_DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
        end
    endgenerate

    // A score change arriving mid-conversion is picked up on the next IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            held_bin_reg <= '0;
            sh_reg       <= '0;
            bcd_reg      <= '0;
            cnt_reg      <= '0;
            digits_reg   <= '0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (score != held_bin_reg) begin
                        held_bin_reg <= score;
                        sh_reg       <= score;
                        bcd_reg      <= '0;
                        cnt_reg      <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_reg <= {bcd_adj[BCD_W-2:0], sh_reg[SCORE_W-1]};
                    sh_reg  <= sh_reg << 1;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(SCORE_W - 1))
                        state_reg <= DONE;
                end
                DONE: begin
                    digits_reg <= (32'(held_bin_reg) > MAX_VAL) ? {SCORE_DIGITS{4'd9}} : bcd_reg;
                    busy_reg   <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign digits = digits_reg;
    assign busy   = busy_reg;

endmodule

// File: rtl/flappy_pixel_pipe.sv
// Two-stage pixel generator: bird, tubes, blinking game-over score and
// per-frame bird/tube collision flag.
module flappy_pixel_pipe
    import flappy_pkg::*;
#(
    parameter int NUM_TUBES    = 3,
    parameter int SCORE_W      = 8,
    parameter int SCORE_DIGITS = 3,
    parameter int BIRD_X       = 364,
    parameter int BIRD_HALF    = 15,
    parameter int TUBE_HALF_W  = 30,
    parameter int GAP_HALF     = 30,
    parameter int DIG_X0       = 544,
    parameter int DIG_PITCH    = 120,
    parameter int BLINK_FRAMES = 30,
    parameter int LZ_BLANK     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bright,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic [9:0]              bird_y_pos,
    input  logic [10*NUM_TUBES-1:0] tube_x_pos,
    input  logic [10*NUM_TUBES-1:0] tube_y_pos,
    input  logic                    game_end,
    input  logic [SCORE_W-1:0]      score,
    output logic [7:0]              rgb,
    output logic                    frame_hit,
    output logic                    hit_valid,
    output logic                    bcd_busy
);

    localparam int          DW  = 4 * SCORE_DIGITS;
    localparam logic [10:0] BX  = 11'(BIRD_X);
    localparam logic [10:0] BH  = 11'(BIRD_HALF);
    localparam logic [10:0] TW  = 11'(TUBE_HALF_W);
    localparam logic [10:0] GH  = 11'(GAP_HALF);

    function automatic logic [10:0] sat_sub(input logic [10:0] a, input logic [10:0] b);
        return (a > b) ? a - b : 11'd0;
    endfunction

    logic [10:0]             x11, y11, by11;
    logic                    bird_hit;
    logic [NUM_TUBES-1:0]    tube_hits;
    logic [DW-1:0]           digits;
    logic [SCORE_DIGITS-1:0] dig_nz, dig_lit;

    assign x11  = {1'b0, x};
    assign y11  = {1'b0, y};
    assign by11 = {1'b0, bird_y_pos};
    assign bird_hit = (x11 >= sat_sub(BX, BH)) && (x11 <= BX + BH) &&
                      (y11 >= sat_sub(by11, BH)) && (y11 <= by11 + BH);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TUBES; gi++) begin : g_tube
            logic [10:0] tx, ty;
            assign tx = {1'b0, tube_x_pos[10*gi +: 10]};
            assign ty = {1'b0, tube_y_pos[10*gi +: 10]};
            assign tube_hits[gi] = (x11 >= sat_sub(tx, TW)) && (x11 <= tx + TW) &&
                                   ((y11 >= ty + GH) || (y11 <= sat_sub(ty, GH)));
        end

        for (gi = 0; gi < SCORE_DIGITS; gi++) begin : g_dig
            localparam logic [10:0] X0 = 11'(DIG_X0 - gi * DIG_PITCH);
            logic [3:0] d;
            logic       shown;
            assign d          = digits[4*gi +: 4];
            assign dig_nz[gi] = (d != 4'd0);
            // A leading zero is blanked only if every more significant digit is zero too.
            assign shown       = (gi == 0 || LZ_BLANK == 0) ? 1'b1 : |dig_nz[SCORE_DIGITS-1:gi];
            assign dig_lit[gi] = shown && |(seg_region(x11 - X0, y11) & seg_mask(d));
        end
    endgenerate

    flappy_bin2bcd #(.SCORE_W(SCORE_W), .SCORE_DIGITS(SCORE_DIGITS)) u_bcd (
        .clk    (clk),
        .reset  (reset),
        .score  (score),
        .digits (digits),
        .busy   (bcd_busy)
    );

    logic       bright_s1, bird_s1, tube_s1, seg_s1, game_end_s1;
    logic       fs_raw_reg, fs_prev_reg, frame_start, coll_s1;
    logic [7:0] rgb_reg;
    logic       visible_reg, hit_acc_reg, frame_hit_reg, hit_valid_reg;
    logic [15:0] blink_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            bright_s1   <= 1'b0;
            bird_s1     <= 1'b0;
            tube_s1     <= 1'b0;
            seg_s1      <= 1'b0;
            game_end_s1 <= 1'b0;
            fs_raw_reg  <= 1'b0;
            fs_prev_reg <= 1'b0;
            rgb_reg     <= BLACK;
        end else begin
            bright_s1   <= bright;
            bird_s1     <= bird_hit;
            tube_s1     <= |tube_hits;
            seg_s1      <= |dig_lit;
            game_end_s1 <= game_end;
            fs_raw_reg  <= (x == 10'd0) && (y == 10'd0);
            fs_prev_reg <= fs_raw_reg;
            if (!bright_s1)
                rgb_reg <= BLACK;
            else if (game_end_s1)
                rgb_reg <= (seg_s1 && visible_reg) ? WHITE : BLACK;
            else if (bird_s1)
                rgb_reg <= RED;
            else if (tube_s1)
                rgb_reg <= GREEN;
            else
                rgb_reg <= BLUE;
        end
    end

    assign frame_start = fs_raw_reg && !fs_prev_reg;
    assign coll_s1     = bright_s1 && bird_s1 && tube_s1 && !game_end_s1;

    // The frame-start pixel itself belongs to the new frame's accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_acc_reg   <= 1'b0;
            frame_hit_reg <= 1'b0;
            hit_valid_reg <= 1'b0;
            visible_reg   <= 1'b1;
            blink_cnt_reg <= '0;
        end else begin
            hit_valid_reg <= frame_start;
            if (frame_start) begin
                frame_hit_reg <= hit_acc_reg;
                hit_acc_reg   <= coll_s1;
            end else if (coll_s1) begin
                hit_acc_reg <= 1'b1;
            end
            if (!game_end_s1) begin
                blink_cnt_reg <= '0;
                visible_reg   <= 1'b1;
            end else if (frame_start && BLINK_FRAMES != 0) begin
                if (blink_cnt_reg + 16'd1 == 16'(BLINK_FRAMES)) begin
                    blink_cnt_reg <= '0;
                    visible_reg   <= !visible_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + 16'd1;
                end
            end
        end
    end

    assign rgb       = rgb_reg;
    assign frame_hit = frame_hit_reg;
    assign hit_valid = hit_valid_reg;

endmodule
